// File: rtl/l2_mem_pkg.sv
// Shared types for the L2 bank master: FSM states, response payload and
// the read data returned for out-of-range requests.
package l2_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } l2_master_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } l2_resp_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/l2_resp_fifo.sv
// In-order response FIFO with first-word fall-through. A push into an empty
// FIFO is visible on o_data in the same cycle and can be popped without storage.
module l2_resp_fifo
  import l2_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_push,
  input  l2_resp_t      i_push_data,
  input  logic          i_pop,
  output logic          o_valid,
  output l2_resp_t      o_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LP_PTR_LAST = PW'(DEPTH - 1);

  l2_resp_t      r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty  = (r_count == '0);
  assign w_bypass = w_empty && i_push && i_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = i_pop && !w_empty;

  assign o_valid = !w_empty || i_push;
  assign o_data  = w_empty ? i_push_data : r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LP_PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l2_bank_master.sv
// Initiator for one L2 bank: grants upstream requests against response credit,
// drives the bank bus, returns in-order responses and runs the fill engine.
module l2_bank_master
  import l2_mem_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 15,
  parameter int          BANK_WORDS     = 29184,
  parameter int          RESP_DEPTH     = 2,
  parameter logic [31:0] FILL_PATTERN   = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [MEM_ADDR_WIDTH-1:0] add_i,
  input  logic                      wen_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [31:0]               r_rdata_o,
  output logic                      r_err_o,
  input  logic                      init_start_i,
  output logic                      init_busy_o,
  output logic                      init_done_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [3:0]                mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [AW:0]   LP_BANK_WORDS = (AW + 1)'(BANK_WORDS);
  localparam logic [AW-1:0] LP_FILL_LAST  = AW'(BANK_WORDS - 1);
  localparam logic [CW:0]   LP_DEPTH      = (CW + 1)'(RESP_DEPTH);

  if (BANK_WORDS > (2 ** MEM_ADDR_WIDTH)) begin : g_bad_bank_words
    $error("l2_bank_master: BANK_WORDS does not fit in MEM_ADDR_WIDTH");
  end
  if (RESP_DEPTH < 2) begin : g_bad_resp_depth
    $error("l2_bank_master: RESP_DEPTH must be at least 2");
  end

  l2_master_state_e r_state;
  l2_master_state_e w_state_nxt;

  logic [AW-1:0] r_fill_add;
  logic          r_done;
  logic          r_inflight;
  logic          r_inflight_err;
  logic          r_inflight_wr;

  logic          r_mem_wen;
  logic [3:0]    r_mem_be;
  logic [AW-1:0] r_mem_add;
  logic [31:0]   r_mem_wdata;

  logic          w_gnt;
  logic          w_in_range;
  logic          w_fill_access;
  logic          w_access;
  logic          w_pending;
  logic          w_credit;
  logic [CW:0]   w_outstanding;
  logic          w_acc_wen;
  logic [3:0]    w_acc_be;
  logic [AW-1:0] w_acc_add;
  logic [31:0]   w_acc_wdata;

  l2_resp_t      w_push_data;
  l2_resp_t      w_fifo_data;
  logic          w_fifo_valid;
  logic          w_pop;
  logic [CW-1:0] w_fifo_count;

  assign w_in_range    = ({1'b0, add_i} < LP_BANK_WORDS);
  assign w_pending     = (w_fifo_count != '0) || r_inflight;
  assign w_outstanding = {1'b0, w_fifo_count} + (CW + 1)'(r_inflight);
  assign w_credit      = (w_outstanding < LP_DEPTH);

  // rst_i gates the combinational grant/access paths so the bank sees no access while reset is held
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt         = 1'b0;
    w_fill_access = 1'b0;
    case (r_state)
      IDLE: begin
        if (init_start_i) w_state_nxt = w_pending ? DRAIN : FILL;
        else              w_gnt = req_i && w_credit;
      end
      DRAIN: begin
        if (!w_pending) w_state_nxt = FILL;
      end
      FILL: begin
        w_fill_access = 1'b1;
        if (r_fill_add == LP_FILL_LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst_i) begin
      w_gnt         = 1'b0;
      w_fill_access = 1'b0;
    end
  end

  assign w_access = (w_gnt && w_in_range) || w_fill_access;

  always_comb begin
    w_acc_wen   = r_mem_wen;
    w_acc_be    = r_mem_be;
    w_acc_add   = r_mem_add;
    w_acc_wdata = r_mem_wdata;
    if (w_fill_access) begin
      w_acc_wen   = 1'b0;
      w_acc_be    = 4'hF;
      w_acc_add   = r_fill_add;
      w_acc_wdata = FILL_PATTERN;
    end else if (w_gnt && w_in_range) begin
      w_acc_wen   = wen_i;
      w_acc_be    = be_i;
      w_acc_add   = add_i;
      w_acc_wdata = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_fill_add     <= '0;
      r_done         <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_err <= 1'b0;
      r_inflight_wr  <= 1'b0;
      r_mem_wen      <= 1'b1;
      r_mem_be       <= '0;
      r_mem_add      <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_fill_add     <= (r_state == FILL) ? r_fill_add + AW'(1) : '0;
      r_done         <= (r_state == FILL) && (r_fill_add == LP_FILL_LAST);
      r_inflight     <= w_gnt;
      r_inflight_err <= w_gnt && !w_in_range;
      r_inflight_wr  <= w_gnt && !wen_i;
      if (w_access) begin
        r_mem_wen   <= w_acc_wen;
        r_mem_be    <= w_acc_be;
        r_mem_add   <= w_acc_add;
        r_mem_wdata <= w_acc_wdata;
      end
    end
  end

  always_comb begin
    w_push_data.err   = 1'b0;
    w_push_data.rdata = mem_rdata_i;
    if (r_inflight_err) begin
      w_push_data.err   = 1'b1;
      w_push_data.rdata = ERR_RDATA;
    end else if (r_inflight_wr) begin
      w_push_data.rdata = 32'h0;
    end
  end

  assign w_pop = w_fifo_valid && r_ready_i;

  l2_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  assign gnt_o       = w_gnt;
  assign r_valid_o   = w_fifo_valid;
  assign r_rdata_o   = w_fifo_valid ? w_fifo_data.rdata : 32'h0;
  assign r_err_o     = w_fifo_valid && w_fifo_data.err;
  assign init_busy_o = (r_state != IDLE);
  assign init_done_o = r_done;
  assign mem_csn_o   = !w_access;
  assign mem_wen_o   = w_acc_wen;
  assign mem_be_o    = w_acc_be;
  assign mem_add_o   = w_acc_add;
  assign mem_wdata_o = w_acc_wdata;

endmodule

// File: tb/tb_l2_bank_master.sv
// Directed bench for l2_bank_master: single-port bank model, hand-computed
// expected responses, credit limiting, out-of-range, fill engine and reset abort.
module tb_l2_bank_master;

  localparam int          AW   = 15;
  localparam int          BW   = 29184;
  localparam int          LAST = BW - 1;
  localparam int          DEP  = 2;
  localparam logic [31:0] PAT  = 32'hA5A55A5A;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic [AW-1:0] add_i = '0;
  logic          wen_i = 1'b1;
  logic [3:0]    be_i = '0;
  logic [31:0]   wdata_i = '0;
  logic          r_valid_o;
  logic          r_ready_i = 1'b0;
  logic [31:0]   r_rdata_o;
  logic          r_err_o;
  logic          init_start_i = 1'b0;
  logic          init_busy_o;
  logic          init_done_o;
  logic          mem_csn_o;
  logic          mem_wen_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_add_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_model [2**AW];
  int unsigned n_mem_wr = 0;

  always #5 clk_i = ~clk_i;

  l2_bank_master #(
    .MEM_ADDR_WIDTH (AW),
    .BANK_WORDS     (BW),
    .RESP_DEPTH     (DEP),
    .FILL_PATTERN   (PAT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .add_i        (add_i),
    .wen_i        (wen_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .r_valid_o    (r_valid_o),
    .r_ready_i    (r_ready_i),
    .r_rdata_o    (r_rdata_o),
    .r_err_o      (r_err_o),
    .init_start_i (init_start_i),
    .init_busy_o  (init_busy_o),
    .init_done_o  (init_done_o),
    .mem_csn_o    (mem_csn_o),
    .mem_wen_o    (mem_wen_o),
    .mem_be_o     (mem_be_o),
    .mem_add_o    (mem_add_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always @(posedge clk_i) begin
    if (!mem_csn_o) begin
      if (!mem_wen_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem_model[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        n_mem_wr <= n_mem_wr + 1;
      end else begin
        mem_rdata_i <= mem_model[mem_add_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request with r_ready high: grant same cycle, response one cycle later.
  task automatic access(input string tag, input logic wen, input logic [AW-1:0] add,
                        input logic [3:0] be, input logic [31:0] wd, input logic exp_csn,
                        input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk_i);
    req_i = 1'b1; wen_i = wen; add_i = add; be_i = be; wdata_i = wd; r_ready_i = 1'b1;
    #1;
    chk({tag, ".gnt"}, gnt_o, 1);
    chk({tag, ".csn"}, mem_csn_o, exp_csn);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    chk({tag, ".rvalid"}, r_valid_o, 1);
    chk({tag, ".rdata"}, r_rdata_o, exp_rd);
    chk({tag, ".rerr"}, r_err_o, exp_err);
  endtask

  initial begin
    int n_fill, n_bad, n_done, post, done_ok, prev_wr, prev_add, cur_wr, n_gnt;
    int unsigned wr_snap;

    @(negedge clk_i);
    req_i = 1'b1; wen_i = 1'b0;
    #1;
    chk("rst.gnt", gnt_o, 0);
    chk("rst.rvalid", r_valid_o, 0);
    chk("rst.csn", mem_csn_o, 1);
    chk("rst.wen", mem_wen_o, 1);
    chk("rst.busy", init_busy_o, 0);
    req_i = 1'b0; wen_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;

    access("wr100", 1'b0, 15'h100, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    access("rd100", 1'b1, 15'h100, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    access("wr200", 1'b0, 15'h200, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0);
    access("wr200b", 1'b0, 15'h200, 4'b0010, 32'h0000AB00, 1'b0, 32'h0, 1'b0);
    access("rd200", 1'b1, 15'h200, 4'hF, 32'h0, 1'b0, 32'h1122AB44, 1'b0);
    access("wr10", 1'b0, 15'h10, 4'hF, 32'h10101010, 1'b0, 32'h0, 1'b0);
    access("wr11", 1'b0, 15'h11, 4'hF, 32'h11111111, 1'b0, 32'h0, 1'b0);
    access("oor", 1'b1, 15'(BW), 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1);

    // Credit limit: four back-to-back reads with the response port stalled
    n_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      req_i = 1'b1; wen_i = 1'b1; add_i = 15'(16 + i); r_ready_i = 1'b0;
      #1;
      chk($sformatf("b2b.gnt%0d", i), gnt_o, (i < DEP) ? 1 : 0);
      if (gnt_o) n_gnt++;
    end
    @(negedge clk_i);
    #1;
    chk("b2b.gnt_full", gnt_o, 0);
    chk("b2b.ngnt", n_gnt, DEP);
    req_i = 1'b0; r_ready_i = 1'b1;
    #1;
    chk("b2b.v0", r_valid_o, 1);
    chk("b2b.d0", r_rdata_o, 32'h10101010);
    @(negedge clk_i);
    #1;
    chk("b2b.v1", r_valid_o, 1);
    chk("b2b.d1", r_rdata_o, 32'h11111111);
    @(negedge clk_i);
    #1;
    chk("b2b.empty", r_valid_o, 0);

    access("wr0", 1'b0, 15'h0, 4'hF, 32'h0BAD0000, 1'b0, 32'h0, 1'b0);
    access("wrlast", 1'b0, 15'(LAST), 4'hF, 32'h0BADFFFF, 1'b0, 32'h0, 1'b0);

    // Two reads pending, then init: must drain before filling
    @(negedge clk_i);
    r_ready_i = 1'b0; req_i = 1'b1; wen_i = 1'b1; add_i = 15'h0;
    #1;
    chk("drn.gnt0", gnt_o, 1);
    @(negedge clk_i);
    add_i = 15'(LAST);
    #1;
    chk("drn.gnt1", gnt_o, 1);
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("drn.d0", r_rdata_o, 32'h0BAD0000);
    r_ready_i = 1'b1;
    @(negedge clk_i);
    r_ready_i = 1'b0; init_start_i = 1'b1; req_i = 1'b1; wen_i = 1'b1; add_i = 15'h5;
    #1;
    chk("drn.init_wins", gnt_o, 0);
    chk("drn.d1", r_rdata_o, 32'h0BADFFFF);
    @(negedge clk_i);
    init_start_i = 1'b0;
    #1;
    chk("drn.busy", init_busy_o, 1);
    chk("drn.gnt", gnt_o, 0);
    chk("drn.csn", mem_csn_o, 1);
    chk("drn.rvalid", r_valid_o, 1);
    req_i = 1'b0; r_ready_i = 1'b1;

    n_fill = 0; n_bad = 0; n_done = 0; post = 0; done_ok = 0; prev_wr = 0; prev_add = 0;
    for (int c = 0; c < BW + 50; c++) begin
      @(negedge clk_i);
      #1;
      cur_wr = (!mem_csn_o && !mem_wen_o) ? 1 : 0;
      if (cur_wr != 0) begin
        if (int'(mem_add_o) != n_fill || mem_be_o != 4'hF || mem_wdata_o != PAT) n_bad++;
        n_fill++;
      end
      if (init_done_o) begin
        n_done++;
        if (prev_wr != 0 && prev_add == LAST && cur_wr == 0) done_ok = 1;
      end
      prev_wr = cur_wr;
      prev_add = int'(mem_add_o);
      if (n_done != 0) post++;
      if (post > 3) break;
    end
    chk("fill.count", n_fill, BW);
    chk("fill.bad", n_bad, 0);
    chk("fill.done_pulses", n_done, 1);
    chk("fill.done_timing", done_ok, 1);
    chk("fill.busy_end", init_busy_o, 0);

    access("rdf0", 1'b1, 15'h0, 4'hF, 32'h0, 1'b0, PAT, 1'b0);
    access("rdflast", 1'b1, 15'(LAST), 4'hF, 32'h0, 1'b0, PAT, 1'b0);
    access("rdf100", 1'b1, 15'h100, 4'hF, 32'h0, 1'b0, PAT, 1'b0);

    // Reset in the middle of a fill
    @(negedge clk_i);
    init_start_i = 1'b1;
    @(negedge clk_i);
    init_start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #1;
    chk("rf.busy", init_busy_o, 1);
    chk("rf.csn_active", mem_csn_o, 0);
    #2;
    rst_i = 1'b1; req_i = 1'b1; wen_i = 1'b0; add_i = 15'h5;
    #1;
    wr_snap = n_mem_wr;
    chk("rf.gnt", gnt_o, 0);
    chk("rf.rvalid", r_valid_o, 0);
    chk("rf.rdata", r_rdata_o, 0);
    chk("rf.rerr", r_err_o, 0);
    chk("rf.busy0", init_busy_o, 0);
    chk("rf.done", init_done_o, 0);
    chk("rf.csn", mem_csn_o, 1);
    chk("rf.wen", mem_wen_o, 1);
    chk("rf.be", mem_be_o, 0);
    chk("rf.add", mem_add_o, 0);
    chk("rf.wdata", mem_wdata_o, 0);
    repeat (5) @(negedge clk_i);
    chk("rf.no_writes", n_mem_wr, wr_snap);
    req_i = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rf.idle_busy", init_busy_o, 0);
    chk("rf.idle_csn", mem_csn_o, 1);
    chk("rf.idle_writes", n_mem_wr, wr_snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
